dht11_ascii_tx_queue: RTL and testbench

- Downstream stage of the DHT11 sensor top. Consumes the byte stream that top produces on ascii/go_ascii.
- Buffers the bytes in a synchronous FIFO and hands them one at a time to the UART transmitter, using a start/busy handshake.
- Keeps ASCII bursts intact while the UART is slower than the producer. Flags overflow when bytes are lost.

---
 rtl/dht11_pkg.sv | 9 +
 rtl/sync_byte_fifo.sv | 40 ++++
 rtl/dht11_ascii_tx_queue.sv | 80 ++++++++
 tb/tb_dht11_ascii_tx_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared FSM state type, queue defaults and ASCII constants for the DHT11 chain
package dht11_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BUSY = 2'd1, WAIT_DONE = 2'd2} tx_state_e;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_BUSY_TIMEOUT = 1023;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
endpackage

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO with registered count and push/pop arbitration
module sync_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [7:0]        wr_data,
  input  logic              pop,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              drop
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic push;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  // a pop in the same cycle frees the slot, so a full queue may still accept
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + {ADDR_W'(0), push} - {ADDR_W'(0), pop};
    end
  end
endmodule

// File: rtl/dht11_ascii_tx_queue.sv
// dht11_ascii_tx_queue: buffers ASCII bytes and feeds them to a UART via a start/busy handshake
module dht11_ascii_tx_queue
  import dht11_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_ascii,
  input  logic [7:0]        ascii,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  output logic              timeout_err
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  tx_state_e state, state_n;
  logic [TW-1:0] tmo, tmo_n;
  logic pop, drop, tmo_hit;
  logic [7:0] rd_data;
  sync_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_req(go_ascii),
    .wr_data(ascii),
    .pop(pop),
    .rd_data(rd_data),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty),
    .drop(drop)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    tmo_n = tmo;
    pop = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && !tx_busy) begin
        pop = 1'b1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) begin
        state_n = WAIT_DONE;
        tmo_n = '0;
      end else if (tmo == TMO_LAST) begin
        tmo_hit = 1'b1;
        state_n = IDLE;
        tmo_n = '0;
      end else tmo_n = tmo + TW'(1);
      WAIT_DONE: if (!tx_busy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // the byte popped by a timed-out handshake is not retried
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo <= '0;
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tmo <= tmo_n;
      tx_start <= pop;
      if (pop) tx_data <= rd_data;
      if (drop) overflow <= 1'b1;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dht11_ascii_tx_queue.sv
// tb_dht11_ascii_tx_queue: randomized and directed checks against a queue-based reference model
module tb_dht11_ascii_tx_queue;
  import dht11_pkg::*;
  localparam int DEPTH = 16;
  localparam int BT = 1023;
  localparam int FRAME = 10;
  logic clk = 1'b0, rst = 1'b1, go_ascii = 1'b0, tx_busy = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic tx_start, fifo_full, fifo_empty, overflow, timeout_err;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  dht11_ascii_tx_queue dut (
    .clk(clk), .rst(rst), .go_ascii(go_ascii), .ascii(ascii), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: a byte queue plus one outstanding-handshake record
  logic [7:0] mq[$];
  bit armed = 0, m_pending = 0, m_seen = 0, m_start = 0, m_ovf = 0, m_tmo = 0;
  int m_waited = 0;
  logic [7:0] m_data = 8'h00;
  initial forever begin
    bit can_pop;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pending = 0; m_seen = 0; m_waited = 0;
      m_start = 0; m_data = 8'h00; m_ovf = 0; m_tmo = 0;
      armed = 1;
    end else begin
      can_pop = !m_pending && mq.size() > 0 && !tx_busy;
      if (m_pending) begin
        if (!m_seen) begin
          if (tx_busy) m_seen = 1;
          else begin
            m_waited++;
            if (m_waited == BT) begin m_pending = 0; m_tmo = 1; end
          end
        end else if (!tx_busy) m_pending = 0;
      end
      m_start = can_pop;
      if (can_pop) begin
        m_data = mq.pop_front();
        m_pending = 1; m_seen = 0; m_waited = 0;
      end
      if (go_ascii) begin
        if (mq.size() < DEPTH) mq.push_back(ascii);
        else m_ovf = 1;
      end
    end
  end
  // per-cycle comparison and transfer log
  logic [7:0] sent[$];
  int start_cyc[$];
  int cyc = 0, n_starts = 0, peak = 0, tmo_cyc = 0;
  bit tmo_seen = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (armed) begin
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_data);
      chk("fifo_count", fifo_count, mq.size());
      chk("fifo_full", fifo_full, mq.size() == DEPTH);
      chk("fifo_empty", fifo_empty, mq.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("timeout_err", timeout_err, m_tmo);
      if (tx_start) begin sent.push_back(tx_data); start_cyc.push_back(cyc); n_starts++; end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (timeout_err && !tmo_seen) begin tmo_seen = 1; tmo_cyc = cyc; end
    end
  end
  // UART stand-in: 0 = normal frames, 1 = hold busy, 2 = never answer
  int uart_mode = 0, busy_left = 0;
  bit rand_frame = 0;
  initial forever begin
    @(negedge clk);
    if (uart_mode == 1) tx_busy = 1'b1;
    else if (uart_mode == 2) tx_busy = 1'b0;
    else begin
      tx_busy = busy_left > 0;
      if (busy_left > 0) busy_left--;
    end
    if (tx_start && uart_mode == 0) busy_left = rand_frame ? int'($urandom_range(1, 12)) : FRAME;
  end
  task automatic write_byte(input logic [7:0] b);
    go_ascii = 1'b1;
    ascii = b;
    @(negedge clk);
    go_ascii = 1'b0;
  endtask
  task automatic drain(input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      done = mq.size() == 0 && !m_pending;
    end
    chk("drain_done", done, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout_err, 0);
  endtask
  initial begin
    logic [7:0] burst[6];
    logic [7:0] fill[$];
    burst = '{8'h32, 8'h35, 8'h2E, 8'h33, CR, LF};
    @(negedge clk);
    do_reset();
    // single byte: empty drops in N+1, tx_start only in N+2
    sent.delete(); n_starts = 0;
    write_byte(8'h32);
    chk("single_empty_n1", fifo_empty, 0);
    chk("single_count_n1", fifo_count, 1);
    chk("single_start_n1", tx_start, 0);
    @(negedge clk);
    chk("single_start_n2", tx_start, 1);
    chk("single_data_n2", tx_data, 8'h32);
    chk("single_count_n2", fifo_count, 0);
    @(negedge clk);
    chk("single_start_n3", tx_start, 0);
    repeat (20) @(negedge clk);
    chk("single_transfers", n_starts, 1);
    // burst ordering with the UART busy while the bytes arrive
    uart_mode = 1;
    repeat (2) @(negedge clk);
    sent.delete(); peak = 0;
    foreach (burst[i]) write_byte(burst[i]);
    uart_mode = 0;
    drain(200);
    chk("burst_peak", peak, 6);
    chk("burst_len", sent.size(), 6);
    foreach (burst[i]) if (i < sent.size()) chk($sformatf("burst_byte%0d", i), sent[i], burst[i]);
    // overflow: 17 writes against a stalled UART
    uart_mode = 1;
    repeat (2) @(negedge clk);
    sent.delete(); fill.delete();
    for (int i = 0; i < 16; i++) begin
      fill.push_back(8'($urandom));
      write_byte(fill[i]);
    end
    chk("ovf_full16", fifo_full, 1);
    chk("ovf_pre", overflow, 0);
    write_byte(8'hEE);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", fifo_count, 16);
    uart_mode = 0;
    drain(400);
    chk("ovf_sent_len", sent.size(), 16);
    foreach (fill[i]) if (i < sent.size()) chk($sformatf("ovf_byte%0d", i), sent[i], fill[i]);
    // full queue with a write landing on the pop cycle
    do_reset();
    uart_mode = 1;
    repeat (2) @(negedge clk);
    sent.delete(); fill.delete();
    for (int i = 0; i < 16; i++) begin
      fill.push_back(8'($urandom));
      write_byte(fill[i]);
    end
    uart_mode = 0;
    begin
      bit rel = 0;
      for (int i = 0; i < 10 && !rel; i++) begin
        @(negedge clk);
        #1 rel = !tx_busy;
      end
      chk("fullpop_release", rel, 1);
    end
    write_byte(8'hAA);
    chk("fullpop_start", tx_start, 1);
    chk("fullpop_count", fifo_count, 16);
    chk("fullpop_ovf", overflow, 0);
    drain(400);
    chk("fullpop_len", sent.size(), 17);
    if (sent.size() == 17) chk("fullpop_last", sent[16], 8'hAA);
    chk("fullpop_ovf_end", overflow, 0);
    // timeout: the UART never answers
    do_reset();
    uart_mode = 2;
    sent.delete(); start_cyc.delete(); tmo_seen = 0;
    write_byte(8'h41);
    write_byte(8'h42);
    repeat (2 * BT + 20) @(negedge clk);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_starts", start_cyc.size(), 2);
    if (start_cyc.size() == 2) begin
      chk("tmo_latency", tmo_cyc - start_cyc[0], BT);
      chk("tmo_restart", start_cyc[1] - start_cyc[0], BT + 1);
      chk("tmo_byte1", sent[1], 8'h42);
    end
    // reset while a frame is in flight with five bytes queued
    do_reset();
    uart_mode = 0;
    for (int i = 0; i < 6; i++) write_byte(8'h30 + 8'(i));
    begin
      bit hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        hit = m_pending && m_seen && mq.size() == 5;
        if (!hit) @(negedge clk);
      end
      chk("midrst_reach", hit, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", fifo_count, 0);
    chk("midrst_empty", fifo_empty, 1);
    chk("midrst_start", tx_start, 0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    chk("midrst_flags", {overflow, timeout_err}, 0);
    n_starts = 0;
    repeat (40) @(negedge clk);
    chk("midrst_no_stale", n_starts, 0);
    // randomized traffic with random frame lengths
    rand_frame = 1;
    for (int i = 0; i < 3000; i++) begin
      go_ascii = $urandom_range(0, 3) == 0;
      ascii = 8'($urandom);
      @(negedge clk);
    end
    go_ascii = 1'b0;
    drain(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
